// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encoding, default latencies, result payload.
package md_pkg;

  localparam int unsigned MD_OP_W = 4;
  localparam int unsigned MD_XLEN = 32;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  localparam int unsigned MD_MULT_LAT = 5;
  localparam int unsigned MD_DIV_LAT  = 10;

  typedef struct packed {
    logic [MD_XLEN-1:0] hi;
    logic [MD_XLEN-1:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result for one MD op; madd family only when MD_MADD_EN is defined.
module md_calc
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs,
  input  logic [31:0]        rt,
  input  logic [31:0]        hi,
  input  logic [31:0]        lo,
  output md_res_t            res_c
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] div_rt;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};
    acc    = {hi, lo};
    abs_rs = rs[31] ? 32'(-rs) : rs;
    abs_rt = rt[31] ? 32'(-rt) : rt;
    div_rt = (rt == 32'd0) ? 32'd1 : rt;
    if (op == MD_DIV) begin
      uq = abs_rs / ((abs_rt == 32'd0) ? 32'd1 : abs_rt);
      ur = abs_rs % ((abs_rt == 32'd0) ? 32'd1 : abs_rt);
    end else begin
      uq = rs / div_rt;
      ur = rs % div_rt;
    end
    sq = (rs[31] ^ rt[31]) ? 32'(-uq) : uq;
    sr = rs[31] ? 32'(-ur) : ur;

    res_c = '{hi: hi, lo: lo};
    case (op)
      MD_MULT:  res_c = prod_s;
      MD_MULTU: res_c = prod_u;
      MD_DIV:   if (rt != 32'd0) res_c = '{hi: sr, lo: sq};
      MD_DIVU:  if (rt != 32'd0) res_c = '{hi: ur, lo: uq};
`ifdef MD_MADD_EN
      MD_MADD:  res_c = acc + prod_s;
      MD_MADDU: res_c = acc + prod_u;
      MD_MSUB:  res_c = acc - prod_s;
      MD_MSUBU: res_c = acc - prod_u;
`endif
      default:  res_c = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency ops with hazard stall.
// Optional madd/maddu/msub/msubu support is compiled in with `define MD_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] count;
  md_res_t          pend;
  md_res_t          calc_c;
  logic             is_div_c;
  logic             is_mul_c;
  logic             start_c;

  md_calc u_calc (
    .op    (md_op),
    .rs    (rs_val),
    .rt    (rt_val),
    .hi    (hi),
    .lo    (lo),
    .res_c (calc_c)
  );

  // Classify the E-stage op; an op only starts when the unit is idle.
  always_comb begin
    is_div_c = (md_op == MD_DIV) || (md_op == MD_DIVU);
    is_mul_c = (md_op == MD_MULT) || (md_op == MD_MULTU);
`ifdef MD_MADD_EN
    is_mul_c = is_mul_c || (md_op == MD_MADD) || (md_op == MD_MADDU) ||
               (md_op == MD_MSUB) || (md_op == MD_MSUBU);
`endif
    start_c  = (is_div_c || is_mul_c) && !busy;
    stall_md = d_md_use && (busy || start_c);
  end

  // Latency counter, pending result and HI/LO commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      count <= '0;
      pend  <= '0;
    end else if (start_c) begin
      pend  <= calc_c;
      busy  <= 1'b1;
      count <= is_div_c ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (busy) begin
      if (count == CNT_W'(1)) begin
        hi    <= pend.hi;
        lo    <= pend.lo;
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end else if (md_op == MD_MTHI) begin
      hi <= rs_val;
    end else if (md_op == MD_MTLO) begin
      lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table, hand sequences, random ops vs a 64-bit model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit madd_family(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  // Expected busy cycles for an op.
  function automatic int lat_of(input logic [3:0] op);
    if (op == MD_MULT || op == MD_MULTU) return MD_MULT_LAT;
    if (op == MD_DIV || op == MD_DIVU) return MD_DIV_LAT;
`ifdef MD_MADD_EN
    if (madd_family(op)) return MD_MULT_LAT;
`endif
    return 0;
  endfunction

  // Architectural {hi,lo} after op, computed with wide integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint q;
    longint rm;
    logic [63:0] r = acc;
    case (op)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = 64'(ua * ub);
      MD_DIV:   if (b != 0) begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      MD_DIVU:  if (b != 0) begin q = ua / ub; rm = ua % ub; r = {rm[31:0], q[31:0]}; end
      MD_MTHI:  r[63:32] = a;
      MD_MTLO:  r[31:0] = a;
`ifdef MD_MADD_EN
      MD_MADD:  r = acc + 64'(sa * sb);
      MD_MADDU: r = acc + 64'(ua * ub);
      MD_MSUB:  r = acc - 64'(sa * sb);
      MD_MSUBU: r = acc - 64'(ua * ub);
`endif
      default:  r = acc;
    endcase
    return r;
  endfunction

  // Issue op for one cycle, then count busy cycles (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    md_op = MD_NONE;
    lat = 0;
    while (busy && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [63:0] m_acc;
    logic [63:0] exp;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[2] = '{MD_DIVU,  32'd7,        32'd2,        32'h0,        32'h0,        32'd1,        32'd3,        10};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1234,     32'h5678,     32'h0,        32'h80000000, 10};
    vecs[4] = '{MD_DIV,   32'd100,      32'd0,        32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 32'h12345678, 10};
    vecs[5] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 5};
    vecs[6] = '{MD_DIVU,  32'd5,        32'd0,        32'd1,        32'd2,        32'd1,        32'd2,        10};
    vecs[7] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'd1,        32'hFFFFFFFD, 10};
`ifdef MD_MADD_EN
    vecs[8] = '{MD_MADD,  32'd2,        32'd3,        32'h0,        32'd5,        32'h0,        32'd11,       5};
    vecs[9] = '{MD_MSUBU, 32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
`else
    vecs[8] = '{MD_MADD,  32'd2,        32'd3,        32'h0,        32'd5,        32'h0,        32'd5,        0};
    vecs[9] = '{MD_MSUBU, 32'd1,        32'd1,        32'h0,        32'h0,        32'h0,        32'h0,        0};
`endif

    reset = 1'b1; md_op = MD_NONE; rs_val = '0; rt_val = '0; d_md_use = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_stall", 64'(stall_md), 64'h0);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      do_op(MD_MTHI, vecs[i].pre_hi, 32'd0, lat);
      do_op(MD_MTLO, vecs[i].pre_lo, 32'd0, lat);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    end

    // mthi while idle: one-cycle update, never busy.
    md_op = MD_MTHI; rs_val = 32'h1234;
    @(negedge clk);
    md_op = MD_NONE;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'h0);

    // Stall covers the start cycle plus every busy cycle.
    md_op = MD_MULT; rs_val = 32'd4; rt_val = 32'd5; d_md_use = 1'b1;
    #1;
    n = stall_md ? 1 : 0;
    for (int k = 0; k < 40 && stall_md; k++) begin
      @(negedge clk);
      md_op = MD_NONE;
      #1;
      if (stall_md) n++;
    end
    check("stall_cycles", 64'(n), 64'(1 + MD_MULT_LAT));
    check("stall_end_busy", 64'(busy), 64'h0);
    d_md_use = 1'b0;
    check("stall_result_lo", 64'(lo), 64'd20);

    // Ops arriving while busy are ignored and do not extend latency.
    do_op(MD_MTHI, 32'h0, 32'd0, lat);
    md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    md_op = MD_MTHI; rs_val = 32'h777;
    @(negedge clk);
    md_op = MD_DIV; rs_val = 32'd9; rt_val = 32'd2;
    @(negedge clk);
    md_op = MD_NONE;
    lat = 2;
    while (busy && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    check("ignore_lat", 64'(lat), 64'(MD_MULT_LAT));
    check("ignore_hilo", {hi, lo}, 64'd6);

    // Reset in busy cycle 3 of a divide aborts it.
    do_op(MD_MTHI, 32'h55, 32'd0, lat);
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    md_op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; d_md_use = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    check("abort_stall", 64'(stall_md), 64'h0);
    d_md_use = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_commit", {hi, lo}, 64'h0);

    // Random ops against the model.
    m_acc = {$urandom(), $urandom()};
    do_op(MD_MTHI, m_acc[63:32], 32'd0, lat);
    do_op(MD_MTLO, m_acc[31:0], 32'd0, lat);
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(1, 10));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exp = ref_md(op, a, b, m_acc);
      do_op(op, a, b, lat);
      check($sformatf("rnd%0d_op%0d_lat", k, op), 64'(lat), 64'(lat_of(op)));
      check($sformatf("rnd%0d_op%0d_hilo", k, op), {hi, lo}, exp);
      m_acc = exp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
